// File: rtl/dap_alu_pkg.sv
// rtl/dap_alu_pkg.sv - shared op encoding and width constant for dap_alu
package dap_alu_pkg;

  localparam int DAP_ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_EQ  = 3'd2,
    OP_GT  = 3'd3,
    OP_GE  = 3'd4,
    OP_LT  = 3'd5,
    OP_AND = 3'd6,
    OP_OR  = 3'd7
  } alu_op_e;

  function automatic logic is_compare(input alu_op_e op);
    return (op == OP_EQ) || (op == OP_GT) || (op == OP_GE) || (op == OP_LT);
  endfunction

endpackage

// File: rtl/dap_alu_if.sv
// rtl/dap_alu_if.sv - operand/result bundle for dap_alu; flag signals exist only with ALU_FLAGS_EN
interface dap_alu_if
  import dap_alu_pkg::*;
#(
  parameter int WIDTH = DAP_ALU_WIDTH
) ();

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  alu_op_e          Op;
  logic             in_valid;
  logic [WIDTH-1:0] ALU_Out;
  logic             out_valid;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
`endif

  modport master (
    output A, B, Op, in_valid,
`ifdef ALU_FLAGS_EN
    input  zero, negative, carry, overflow,
`endif
    input  ALU_Out, out_valid
  );

  modport slave (
    input  A, B, Op, in_valid,
`ifdef ALU_FLAGS_EN
    output zero, negative, carry, overflow,
`endif
    output ALU_Out, out_valid
  );

endinterface

// File: rtl/dap_alu_cmp.sv
// rtl/dap_alu_cmp.sv - combinational unsigned comparator feeding the dap_alu result mux
module dap_alu_cmp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o,
  output logic             ge_o,
  output logic             lt_o
);

  // GE and LT are derived from the two primitive compares so all four stay consistent.
  always_comb begin
    eq_o = (a_i == b_i);
    gt_o = (a_i > b_i);
    ge_o = gt_o | eq_o;
    lt_o = ~ge_o;
  end

endmodule

// File: rtl/dap_alu.sv
// rtl/dap_alu.sv - one-cycle registered ALU (add/sub/compare/logic); status flags with ALU_FLAGS_EN
module dap_alu
  import dap_alu_pkg::*;
#(
  parameter int WIDTH = DAP_ALU_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  dap_alu_if.slave bus
);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_ge;
  logic             cmp_lt;
  logic             cmp_sel;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] alu_out_q;
  logic             out_valid_q;

  dap_alu_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a_i  (bus.A),
    .b_i  (bus.B),
    .eq_o (cmp_eq),
    .gt_o (cmp_gt),
    .ge_o (cmp_ge),
    .lt_o (cmp_lt)
  );

  // Extra top bit captures ADD carry-out and SUB borrow for the flag path.
  always_comb begin
    sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
    diff_ext = {1'b0, bus.A} - {1'b0, bus.B};
    cmp_sel  = 1'b0;
    result_d = '0;
    case (bus.Op)
      OP_ADD:  result_d = sum_ext[WIDTH-1:0];
      OP_SUB:  result_d = diff_ext[WIDTH-1:0];
      OP_EQ:   cmp_sel  = cmp_eq;
      OP_GT:   cmp_sel  = cmp_gt;
      OP_GE:   cmp_sel  = cmp_ge;
      OP_LT:   cmp_sel  = cmp_lt;
      OP_AND:  result_d = bus.A & bus.B;
      OP_OR:   result_d = bus.A | bus.B;
      default: result_d = '0;
    endcase
    if (is_compare(bus.Op)) begin
      result_d = {{(WIDTH-1){1'b0}}, cmp_sel};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        alu_out_q <= result_d;
      end
    end
  end

  assign bus.ALU_Out   = alu_out_q;
  assign bus.out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
  logic carry_d;
  logic overflow_d;
  logic zero_q;
  logic negative_q;
  logic carry_q;
  logic overflow_q;

  // Signed overflow: operands effectively share a sign but the result's sign differs.
  always_comb begin
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (bus.Op)
      OP_ADD: begin
        carry_d    = sum_ext[WIDTH];
        overflow_d = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        carry_d    = ~diff_ext[WIDTH];
        overflow_d = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                     (diff_ext[WIDTH-1] != bus.A[WIDTH-1]);
      end
      default: begin
        carry_d    = 1'b0;
        overflow_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.in_valid) begin
      zero_q     <= (result_d == '0);
      negative_q <= result_d[WIDTH-1];
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_dap_alu.sv
// tb/tb_dap_alu.sv - directed self-checking bench for dap_alu
module tb_dap_alu;
  import dap_alu_pkg::*;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  dap_alu_if #(.WIDTH(W)) bus ();

  dap_alu #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic v);
    @(negedge clk);
    bus.Op       = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic op_check(input string tag, input alu_op_e op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
    step(op, a, b, 1'b1);
    check(tag, {16'd0, bus.ALU_Out}, {16'd0, exp});
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.Op       = OP_ADD;
    bus.in_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {16'd0, bus.ALU_Out}, 32'd0);
    check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("add_wrap", OP_ADD, 16'hFF38, 16'd200, 16'd0);
`ifdef ALU_FLAGS_EN
    check("add_wrap_zero", {31'd0, bus.zero}, 32'd1);
    check("add_wrap_carry", {31'd0, bus.carry}, 32'd1);
    check("add_wrap_ovf", {31'd0, bus.overflow}, 32'd0);
`endif
    op_check("sub_equal", OP_SUB, 16'd45000, 16'd45000, 16'd0);
    op_check("sub_wrap", OP_SUB, 16'd3, 16'hFFFF, 16'd4);
    op_check("sub_plain", OP_SUB, 16'd10, 16'd3, 16'd7);

    op_check("eq_true", OP_EQ, 16'd3, 16'd3, 16'd1);
    op_check("eq_false", OP_EQ, 16'd10, 16'd3, 16'd0);
    op_check("gt_true", OP_GT, 16'd19, 16'd13, 16'd1);
    op_check("gt_equal", OP_GT, 16'd12, 16'd12, 16'd0);
    op_check("ge_equal", OP_GE, 16'd3, 16'd3, 16'd1);
    op_check("ge_false", OP_GE, 16'd2, 16'd9, 16'd0);
    op_check("lt_true", OP_LT, 16'd6, 16'd8, 16'd1);
    op_check("lt_false", OP_LT, 16'd10, 16'd3, 16'd0);
    op_check("gt_unsigned", OP_GT, 16'hFFFF, 16'h0001, 16'd1);
    op_check("lt_unsigned", OP_LT, 16'h8000, 16'h7FFF, 16'd0);

    op_check("and_bits", OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030);
    op_check("or_bits", OP_OR, 16'hF0F0, 16'h3C3C, 16'hFCFC);

    op_check("hold_seed", OP_ADD, 16'd7, 16'd8, 16'd15);
    for (int i = 0; i < 3; i++) begin
      step(OP_SUB, 16'(100 + i), 16'(i), 1'b0);
      check("hold_out", {16'd0, bus.ALU_Out}, 32'd15);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    op_check("stream_0", OP_ADD, 16'd3, 16'd1, 16'd4);
    op_check("stream_1", OP_ADD, 16'd20, 16'd40, 16'd60);
    op_check("stream_2", OP_SUB, 16'd23, 16'd11, 16'd12);

    op_check("pre_reset", OP_ADD, 16'd100, 16'd100, 16'd200);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {16'd0, bus.ALU_Out}, 32'd0);
    check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    step(OP_ADD, 16'd5, 16'd5, 1'b1);
    step(OP_ADD, 16'd6, 16'd6, 1'b1);
    check("rst_hold_out", {16'd0, bus.ALU_Out}, 32'd0);
    check("rst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
    op_check("post_rst_first", OP_OR, 16'h0011, 16'h0100, 16'h0111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
